// File: rtl/cpu_ctrl_seq.sv
// Fetch/decode/execute control sequencer for the 8-bit CPU: drives ALU select and datapath strobes.
// Define CTRL_ILLEGAL_TRAP_EN to add the `illegal` output and trap undefined opcodes into HALT.
module cpu_ctrl_seq #(
    parameter logic [7:0] HALT_OP = 8'hFF,
    parameter int         ALUS_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        ir,
    input  logic              z,
    input  logic              mem_rdy,
    output logic [ALUS_W-1:0] alus,
    output logic              ac_ld,
    output logic              z_ld,
    output logic              r_ld,
    output logic              ir_ld,
    output logic              dr_ld,
    output logic              ar_ld,
    output logic              ar_sel,
    output logic              pc_inc,
    output logic              pc_ld,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              instr_done,
    output logic              halted
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic              illegal
`endif
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDAC = 8'h01;
    localparam logic [7:0] OP_STAC = 8'h02;
    localparam logic [7:0] OP_MVAC = 8'h03;
    localparam logic [7:0] OP_MOVR = 8'h04;
    localparam logic [7:0] OP_JUMP = 8'h05;
    localparam logic [7:0] OP_JMPZ = 8'h06;
    localparam logic [7:0] OP_JPNZ = 8'h07;
    localparam logic [7:0] OP_ADD  = 8'h08;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_INAC = 8'h0A;
    localparam logic [7:0] OP_CLAC = 8'h0B;
    localparam logic [7:0] OP_AND  = 8'h0C;
    localparam logic [7:0] OP_OR   = 8'h0D;
    localparam logic [7:0] OP_XOR  = 8'h0E;
    localparam logic [7:0] OP_NOT  = 8'h0F;

    localparam logic [ALUS_W-1:0] ALU_CLR      = ALUS_W'(0);
    localparam logic [ALUS_W-1:0] ALU_ADD      = ALUS_W'(1);
    localparam logic [ALUS_W-1:0] ALU_SUB      = ALUS_W'(2);
    localparam logic [ALUS_W-1:0] ALU_INC      = ALUS_W'(3);
    localparam logic [ALUS_W-1:0] ALU_PASS_R   = ALUS_W'(4);
    localparam logic [ALUS_W-1:0] ALU_AND      = ALUS_W'(5);
    localparam logic [ALUS_W-1:0] ALU_OR       = ALUS_W'(6);
    localparam logic [ALUS_W-1:0] ALU_NOT      = ALUS_W'(7);
    localparam logic [ALUS_W-1:0] ALU_XOR      = ALUS_W'(8);
    localparam logic [ALUS_W-1:0] ALU_PASS_MEM = ALUS_W'(9);

    typedef enum logic [3:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_F3,
        S_EX1,
        S_EX2,
        S_EX3,
        S_EX4,
        S_HALT
    } state_t;

    state_t state_q, state_d;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    function automatic logic [ALUS_W-1:0] aluSelect(input logic [7:0] op);
        logic [ALUS_W-1:0] sel;
        sel = ALU_CLR;
        case (op)
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_INAC: sel = ALU_INC;
            OP_CLAC: sel = ALU_CLR;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_XOR:  sel = ALU_XOR;
            OP_NOT:  sel = ALU_NOT;
            OP_MOVR: sel = ALU_PASS_R;
            default: sel = ALU_CLR;
        endcase
        return sel;
    endfunction

    logic isHalt, isAlu, isMvac, isNop, isLdac, isStac, isJump, isJmpz, isJpnz;
    logic isMemOp, isBranch, branchTaken, isIllegal;

    // IR is only reloaded in F3, so decoding it live stays stable through EX1..EX4.
    always_comb begin
        isHalt      = (ir == HALT_OP);
        isAlu       = !isHalt && ((ir == OP_MOVR) || ((ir >= OP_ADD) && (ir <= OP_NOT)));
        isMvac      = !isHalt && (ir == OP_MVAC);
        isNop       = !isHalt && (ir == OP_NOP);
        isLdac      = !isHalt && (ir == OP_LDAC);
        isStac      = !isHalt && (ir == OP_STAC);
        isJump      = !isHalt && (ir == OP_JUMP);
        isJmpz      = !isHalt && (ir == OP_JMPZ);
        isJpnz      = !isHalt && (ir == OP_JPNZ);
        isMemOp     = isLdac || isStac;
        isBranch    = isJump || isJmpz || isJpnz;
        branchTaken = isJump || (isJmpz && z) || (isJpnz && !z);
        isIllegal   = !isHalt && (ir > OP_NOT);
    end

    always_comb begin
        state_d    = state_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        alus       = ALU_CLR;
        ac_ld      = 1'b0;
        z_ld       = 1'b0;
        r_ld       = 1'b0;
        ir_ld      = 1'b0;
        dr_ld      = 1'b0;
        ar_ld      = 1'b0;
        ar_sel     = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_F1;
            end

            S_F1: begin
                ar_ld   = 1'b1;
                state_d = S_F2;
            end

            S_F2: begin
                mem_rd = 1'b1;
                if (mem_rdy) begin
                    dr_ld   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_F3;
                end
            end

            S_F3: begin
                ir_ld   = 1'b1;
                state_d = S_EX1;
            end

            S_EX1: begin
                if (isHalt) begin
                    state_d = S_HALT;
                end else if (isAlu) begin
                    alus       = aluSelect(ir);
                    ac_ld      = 1'b1;
                    z_ld       = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_F1;
                end else if (isMvac) begin
                    r_ld       = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_F1;
                end else if (isMemOp || (isBranch && branchTaken)) begin
                    mem_rd = 1'b1;
                    if (mem_rdy) begin
                        dr_ld   = 1'b1;
                        pc_inc  = isMemOp;
                        state_d = S_EX2;
                    end
                end else if (isBranch) begin
                    // Branch not taken: skip over the address operand without reading it.
                    pc_inc     = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_F1;
                end else if (isNop) begin
                    instr_done = 1'b1;
                    state_d    = S_F1;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    illegal_d  = isIllegal;
                    state_d    = S_HALT;
`else
                    instr_done = isIllegal;
                    state_d    = S_F1;
`endif
                end
            end

            S_EX2: begin
                if (isMemOp) begin
                    ar_ld   = 1'b1;
                    ar_sel  = 1'b1;
                    state_d = S_EX3;
                end else begin
                    pc_ld      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_F1;
                end
            end

            S_EX3: begin
                if (isStac) begin
                    mem_wr = 1'b1;
                    if (mem_rdy) begin
                        instr_done = 1'b1;
                        state_d    = S_F1;
                    end
                end else begin
                    mem_rd = 1'b1;
                    if (mem_rdy) begin
                        dr_ld   = 1'b1;
                        state_d = S_EX4;
                    end
                end
            end

            S_EX4: begin
                alus       = ALU_PASS_MEM;
                ac_ld      = 1'b1;
                z_ld       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_F1;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed, table-driven bench for cpu_ctrl_seq; outputs are packed into one vector per cycle.
module tb_cpu_ctrl_seq;

    localparam logic [16:0] HLT   = 17'h00001;
    localparam logic [16:0] DONE  = 17'h00002;
    localparam logic [16:0] MWR   = 17'h00004;
    localparam logic [16:0] MRD   = 17'h00008;
    localparam logic [16:0] PCLD  = 17'h00010;
    localparam logic [16:0] PCINC = 17'h00020;
    localparam logic [16:0] ARSEL = 17'h00040;
    localparam logic [16:0] ARLD  = 17'h00080;
    localparam logic [16:0] DRLD  = 17'h00100;
    localparam logic [16:0] IRLD  = 17'h00200;
    localparam logic [16:0] RLD   = 17'h00400;
    localparam logic [16:0] ZLD   = 17'h00800;
    localparam logic [16:0] ACLD  = 17'h01000;
    localparam logic [16:0] NONE  = 17'h00000;

    typedef struct {
        string       name;
        logic        rst;
        logic [7:0]  ir;
        logic        z;
        logic        rdy;
        logic [16:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ir = 8'h00;
    logic       z = 1'b0;
    logic       mem_rdy = 1'b0;
    logic [3:0] alus;
    logic       ac_ld, z_ld, r_ld, ir_ld, dr_ld, ar_ld, ar_sel;
    logic       pc_inc, pc_ld, mem_rd, mem_wr, instr_done, halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
    logic [16:0] actual;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    cpu_ctrl_seq dut (
        .clk        (clk),
        .rst        (rst),
        .ir         (ir),
        .z          (z),
        .mem_rdy    (mem_rdy),
        .alus       (alus),
        .ac_ld      (ac_ld),
        .z_ld       (z_ld),
        .r_ld       (r_ld),
        .ir_ld      (ir_ld),
        .dr_ld      (dr_ld),
        .ar_ld      (ar_ld),
        .ar_sel     (ar_sel),
        .pc_inc     (pc_inc),
        .pc_ld      (pc_ld),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .instr_done (instr_done),
        .halted     (halted)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal)
`endif
    );

    always #5 clk = ~clk;

    assign actual = {alus, ac_ld, z_ld, r_ld, ir_ld, dr_ld, ar_ld, ar_sel,
                     pc_inc, pc_ld, mem_rd, mem_wr, instr_done, halted};

    function automatic logic [16:0] aluEx(input int n);
        logic [3:0] sel;
        sel = n[3:0];
        return {sel, 13'b0} | ACLD | ZLD | DONE;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well clear of the rising edge.
    task automatic applyStimulus(input logic r, input logic [7:0] op, input logic zf, input logic rdy);
        @(negedge clk);
        rst     = r;
        ir      = op;
        z       = zf;
        mem_rdy = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic addVec(input string name, input logic r, input logic [7:0] op,
                          input logic zf, input logic rdy, input logic [16:0] exp);
        vec_t v;
        v.name = name;
        v.rst  = r;
        v.ir   = op;
        v.z    = zf;
        v.rdy  = rdy;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic addFetch(input string tag, input logic [7:0] op, input logic zf);
        addVec({tag, "_f1"}, 1'b0, op, zf, 1'b1, ARLD);
        addVec({tag, "_f2"}, 1'b0, op, zf, 1'b1, MRD | DRLD | PCINC);
        addVec({tag, "_f3"}, 1'b0, op, zf, 1'b1, IRLD);
    endtask

    task automatic buildTable();
        addVec("rst_idle", 1'b1, 8'h00, 1'b0, 1'b0, NONE);
        addVec("idle_out", 1'b0, 8'h00, 1'b0, 1'b0, NONE);
        addFetch("add", 8'h08, 1'b0);
        addVec("add_ex1", 1'b0, 8'h08, 1'b0, 1'b1, aluEx(1));
        addVec("ldac_f1", 1'b0, 8'h01, 1'b0, 1'b0, ARLD);
        for (int i = 0; i < 3; i++) addVec("ldac_f2_wait", 1'b0, 8'h01, 1'b0, 1'b0, MRD);
        addVec("ldac_f2_rdy", 1'b0, 8'h01, 1'b0, 1'b1, MRD | DRLD | PCINC);
        addVec("ldac_f3", 1'b0, 8'h01, 1'b0, 1'b1, IRLD);
        addVec("ldac_ex1", 1'b0, 8'h01, 1'b0, 1'b1, MRD | DRLD | PCINC);
        addVec("ldac_ex2", 1'b0, 8'h01, 1'b0, 1'b1, ARLD | ARSEL);
        for (int i = 0; i < 2; i++) addVec("ldac_ex3_wait", 1'b0, 8'h01, 1'b0, 1'b0, MRD);
        addVec("ldac_ex3_rdy", 1'b0, 8'h01, 1'b0, 1'b1, MRD | DRLD);
        addVec("ldac_ex4", 1'b0, 8'h01, 1'b0, 1'b1, aluEx(9));
        addFetch("jmpz0", 8'h06, 1'b0);
        addVec("jmpz0_ex1", 1'b0, 8'h06, 1'b0, 1'b0, PCINC | DONE);
        addFetch("jmpz1", 8'h06, 1'b1);
        addVec("jmpz1_ex1_wait", 1'b0, 8'h06, 1'b1, 1'b0, MRD);
        addVec("jmpz1_ex1", 1'b0, 8'h06, 1'b1, 1'b1, MRD | DRLD);
        addVec("jmpz1_ex2", 1'b0, 8'h06, 1'b1, 1'b1, PCLD | DONE);
        addFetch("jpnz1", 8'h07, 1'b1);
        addVec("jpnz1_ex1", 1'b0, 8'h07, 1'b1, 1'b1, PCINC | DONE);
        addFetch("jpnz0", 8'h07, 1'b0);
        addVec("jpnz0_ex1", 1'b0, 8'h07, 1'b0, 1'b1, MRD | DRLD);
        addVec("jpnz0_ex2", 1'b0, 8'h07, 1'b0, 1'b0, PCLD | DONE);
        addFetch("jump", 8'h05, 1'b1);
        addVec("jump_ex1", 1'b0, 8'h05, 1'b1, 1'b1, MRD | DRLD);
        addVec("jump_ex2", 1'b0, 8'h05, 1'b1, 1'b1, PCLD | DONE);
        addFetch("stac", 8'h02, 1'b0);
        addVec("stac_ex1", 1'b0, 8'h02, 1'b0, 1'b1, MRD | DRLD | PCINC);
        addVec("stac_ex2", 1'b0, 8'h02, 1'b0, 1'b1, ARLD | ARSEL);
        addVec("stac_ex3_wait", 1'b0, 8'h02, 1'b0, 1'b0, MWR);
        addVec("stac_ex3_rdy", 1'b0, 8'h02, 1'b0, 1'b1, MWR | DONE);
        addFetch("mvac", 8'h03, 1'b0);
        addVec("mvac_ex1", 1'b0, 8'h03, 1'b0, 1'b1, RLD | DONE);
        addFetch("movr", 8'h04, 1'b0);
        addVec("movr_ex1", 1'b0, 8'h04, 1'b0, 1'b1, aluEx(4));
        addFetch("sub", 8'h09, 1'b0);
        addVec("sub_ex1", 1'b0, 8'h09, 1'b0, 1'b1, aluEx(2));
        addFetch("inac", 8'h0A, 1'b0);
        addVec("inac_ex1", 1'b0, 8'h0A, 1'b0, 1'b0, aluEx(3));
        addFetch("clac", 8'h0B, 1'b0);
        addVec("clac_ex1", 1'b0, 8'h0B, 1'b0, 1'b1, aluEx(0));
        addFetch("and", 8'h0C, 1'b0);
        addVec("and_ex1", 1'b0, 8'h0C, 1'b0, 1'b1, aluEx(5));
        addFetch("or", 8'h0D, 1'b0);
        addVec("or_ex1", 1'b0, 8'h0D, 1'b0, 1'b1, aluEx(6));
        addFetch("xor", 8'h0E, 1'b0);
        addVec("xor_ex1", 1'b0, 8'h0E, 1'b0, 1'b1, aluEx(8));
        addFetch("not", 8'h0F, 1'b0);
        addVec("not_ex1", 1'b0, 8'h0F, 1'b0, 1'b1, aluEx(7));
        addFetch("nop", 8'h00, 1'b0);
        addVec("nop_ex1", 1'b0, 8'h00, 1'b0, 1'b1, DONE);
        addFetch("rstmid", 8'h01, 1'b0);
        addVec("rstmid_ex1", 1'b0, 8'h01, 1'b0, 1'b1, MRD | DRLD | PCINC);
        addVec("rstmid_ex2", 1'b0, 8'h01, 1'b0, 1'b1, ARLD | ARSEL);
        addVec("rstmid_ex3", 1'b1, 8'h01, 1'b0, 1'b0, MRD);
        addVec("rstmid_idle1", 1'b1, 8'h01, 1'b0, 1'b1, NONE);
        addVec("rstmid_idle2", 1'b0, 8'h01, 1'b0, 1'b1, NONE);
        addVec("rstmid_f1", 1'b0, 8'h01, 1'b0, 1'b1, ARLD);
        addVec("rstmid_f2", 1'b0, 8'h01, 1'b0, 1'b1, MRD | DRLD | PCINC);
        addVec("rstmid_f3", 1'b0, 8'h01, 1'b0, 1'b1, IRLD);
        addVec("rstmid_ex1b", 1'b0, 8'h01, 1'b0, 1'b0, MRD);
        addVec("rst_again", 1'b1, 8'h01, 1'b0, 1'b0, MRD);
        addVec("rst_again_idle", 1'b0, 8'h01, 1'b0, 1'b0, NONE);
    endtask

    initial begin
        int         k;
        int         doneCycle;
        int         pcIncCount;
        int         aluLeak;
        logic [3:0] aluAtDone;
        logic       acAtDone;
        logic       rdy;

        buildTable();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ir, vecs[i].z, vecs[i].rdy);
            checkOutput(vecs[i].name, 32'(actual), 32'(vecs[i].exp));
        end

        // LDAC with 3 fetch waits and 2 operand waits, starting from F1; done expected on cycle 12.
        doneCycle  = 0;
        pcIncCount = 0;
        aluLeak    = 0;
        aluAtDone  = 4'h0;
        acAtDone   = 1'b0;
        k          = 0;
        while ((doneCycle == 0) && (k < 50)) begin
            k++;
            rdy = !((k >= 2 && k <= 4) || (k == 9) || (k == 10));
            applyStimulus(1'b0, 8'h01, 1'b0, rdy);
            if (pc_inc) pcIncCount++;
            if (!ac_ld && (alus != 4'h0)) aluLeak++;
            if (instr_done) begin
                doneCycle = k;
                aluAtDone = alus;
                acAtDone  = ac_ld;
            end
        end
        checkOutput("ldac_seq_latency", 32'(doneCycle), 32'd12);
        checkOutput("ldac_seq_pcinc", 32'(pcIncCount), 32'd2);
        checkOutput("ldac_seq_alus", 32'(aluAtDone), 32'd9);
        checkOutput("ldac_seq_acld", 32'(acAtDone), 32'd1);
        checkOutput("ldac_seq_alus_idle", 32'(aluLeak), 32'd0);

        // HALT: held for 20 cycles regardless of ir/z/mem_rdy, leaves only through rst.
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b1);
        checkOutput("halt_f1", 32'(actual), 32'(ARLD));
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b1);
        checkOutput("halt_f2", 32'(actual), 32'(MRD | DRLD | PCINC));
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b1);
        checkOutput("halt_f3", 32'(actual), 32'(IRLD));
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b1);
        checkOutput("halt_ex1", 32'(actual), 32'(NONE));
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 8'(c), c[0], c[1]);
            checkOutput("halt_hold", 32'(actual), 32'(HLT));
        end
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
        checkOutput("halt_rst", 32'(actual), 32'(HLT));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("halt_rst_idle", 32'(actual), 32'(NONE));

        // Undefined opcode 0x42.
        applyStimulus(1'b0, 8'h42, 1'b0, 1'b1);
        checkOutput("ill_f1", 32'(actual), 32'(ARLD));
        applyStimulus(1'b0, 8'h42, 1'b0, 1'b1);
        checkOutput("ill_f2", 32'(actual), 32'(MRD | DRLD | PCINC));
        applyStimulus(1'b0, 8'h42, 1'b0, 1'b1);
        checkOutput("ill_f3", 32'(actual), 32'(IRLD));
        applyStimulus(1'b0, 8'h42, 1'b0, 1'b1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        checkOutput("ill_ex1", 32'(actual), 32'(NONE));
        checkOutput("ill_flag_ex1", 32'(illegal), 32'd0);
        applyStimulus(1'b0, 8'h42, 1'b0, 1'b1);
        checkOutput("ill_halt", 32'(actual), 32'(HLT));
        checkOutput("ill_flag", 32'(illegal), 32'd1);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ill_flag_rst", 32'(illegal), 32'd0);
`else
        checkOutput("ill_ex1_nop", 32'(actual), 32'(DONE));
        applyStimulus(1'b0, 8'h42, 1'b0, 1'b1);
        checkOutput("ill_back_f1", 32'(actual), 32'(ARLD));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
